pkt_framer: RTL

//   Parametrised packet framer between the input sample FIFO and the USB slave FIFO.

---
 rtl/pkt_framer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pkt_framer.sv
// Packet framer: drains one payload from the source FIFO and emits
// sync word, packet counter, payload and XOR checksum to the sink FIFO.
module pkt_framer #(
   parameter int unsigned      DW           = 8,
   parameter int unsigned      CNT_W        = 32,
   parameter int unsigned      PAYLOAD_LEN  = 1020,
   parameter logic [DW-1:0]    SYNC         = 8'hA5,
   parameter logic [CNT_W-1:0] PKT_CNT_INIT = CNT_W'(1),
   parameter int unsigned      DROP_W       = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              src_ready,
   output logic              src_rd,
   input  logic [DW-1:0]     src_data,
   input  logic              dst_afull,
   output logic              dst_wr,
   output logic [DW-1:0]     dst_data,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              busy
);

   localparam int unsigned HW       = CNT_W / DW;
   localparam int unsigned NW       = HW + PAYLOAD_LEN + 2;
   localparam int unsigned IW       = $clog2(NW);
   // idx = index of the word currently on dst_data within the packet
   localparam int unsigned PAY_LAST = HW + PAYLOAD_LEN;
   // src_rd window, in terms of the idx of the cycle carrying the read
   localparam int unsigned RD_FIRST = HW - 1;
   localparam int unsigned RD_LAST  = HW + PAYLOAD_LEN - 2;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_TRL} state_t;

   state_t             state, state_n;
   logic [IW-1:0]      idx, idx_n;
   logic               keep, keep_n;
   logic [CNT_W-1:0]   hdr_sh, hdr_n;
   logic [DW-1:0]      csum, csum_n;
   logic [DW-1:0]      data_n;
   logic               wr_n, rd_n, busy_n;
   logic [CNT_W-1:0]   pkt_cnt_n;
   logic [DROP_W-1:0]  drop_n;

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         idx      <= '0;
         keep     <= 1'b0;
         hdr_sh   <= '0;
         csum     <= '0;
         dst_data <= '0;
         dst_wr   <= 1'b0;
         src_rd   <= 1'b0;
         busy     <= 1'b0;
         pkt_cnt  <= PKT_CNT_INIT;
         drop_cnt <= '0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         keep     <= keep_n;
         hdr_sh   <= hdr_n;
         csum     <= csum_n;
         dst_data <= data_n;
         dst_wr   <= wr_n;
         src_rd   <= rd_n;
         busy     <= busy_n;
         pkt_cnt  <= pkt_cnt_n;
         drop_cnt <= drop_n;
      end
   end

   // Next state and the word to present on the following cycle
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      keep_n    = keep;
      hdr_n     = hdr_sh;
      csum_n    = csum;
      data_n    = dst_data;
      wr_n      = 1'b0;
      busy_n    = 1'b0;
      pkt_cnt_n = pkt_cnt;
      drop_n    = drop_cnt;
      unique case (state)
         S_IDLE: begin
            if (start && src_ready) begin
               state_n = S_HDR;
               idx_n   = '0;
               keep_n  = !dst_afull;
               hdr_n   = pkt_cnt;
               csum_n  = '0;
               data_n  = SYNC;
               wr_n    = !dst_afull;
               busy_n  = 1'b1;
            end
         end
         S_HDR: begin
            idx_n  = idx + IW'(1);
            wr_n   = keep;
            busy_n = 1'b1;
            if (idx < IW'(HW)) begin
               data_n = hdr_sh[CNT_W-1 -: DW];
               hdr_n  = hdr_sh << DW;
            end else begin
               state_n = S_PAY;
               data_n  = src_data;
               csum_n  = csum ^ src_data;
            end
         end
         S_PAY: begin
            idx_n  = idx + IW'(1);
            wr_n   = keep;
            busy_n = 1'b1;
            if (idx < IW'(PAY_LAST)) begin
               data_n = src_data;
               csum_n = csum ^ src_data;
            end else begin
               state_n = S_TRL;
               data_n  = csum;
            end
         end
         S_TRL: begin
            state_n   = S_IDLE;
            pkt_cnt_n = pkt_cnt + CNT_W'(1);
            if (!keep && (drop_cnt != '1)) drop_n = drop_cnt + DROP_W'(1);
         end
         default: state_n = S_IDLE;
      endcase
      // Reads lead their output slot by two cycles (FIFO latency + output register)
      rd_n = busy_n && (idx_n >= IW'(RD_FIRST)) && (idx_n <= IW'(RD_LAST));
   end

endmodule
